adc_scan_ctrl: RTL
==================

# adc_scan_ctrl

Parametrised scan sequencer for the modular ADC's Avalon-ST command/response pair. It walks a programmable slot list of ADC channels and issues one conversion command at a time. Each slot's samples are averaged over 2^AVG_LOG2 conversions, and one averaged result per slot is streamed out. The block sits between the ADC core's command/response ports and the game logic that reads the analogue inputs, and replaces hand-issued single-channel commands.

## Interface
- NUM_SLOTS, 4: slots per frame (1..32)
- CH_W, 5: ADC channel field width
- DATA_W, 12: ADC sample width
- AVG_LOG2, 2: log2 of samples averaged per slot (0..6)
- TIMEOUT_CYC, 1024: response watchdog limit in clock_clk cycles (used only with the macro)

Ports (SW = $clog2(NUM_SLOTS), min 1):
- clock_clk  in  1  sole clock
- reset_sink_reset_n  in  1  asynchronous, active-low reset
- cfg_enable  in  1  scanning permitted
- cfg_continuous  in  1  1 = restart a frame immediately after each frame
- cfg_start  in  1  single-cycle pulse, starts one frame
- cfg_err_clr  in  1  pulse, clears sticky errors
- cfg_slot_ch  in  NUM_SLOTS*CH_W  slot i channel at [i*CH_W +: CH_W]
- command_valid / command_channel / command_startofpacket / command_endofpacket  out  1/CH_W/1/1
- command_ready  in  1
- response_valid / response_channel / response_data  in  1/CH_W/DATA_W
- response_startofpacket, response_endofpacket  in  1  ignored
- result_valid  out  1  one-cycle strobe
- result_slot  out  SW
- result_data  out  DATA_W  averaged sample
- result_frame_end  out  1  high with the last slot's result
- busy  out  1  state != IDLE
- err_channel  out  1  sticky; response channel mismatched
- err_timeout  out  1  sticky; watchdog fired

## Operation
- FSM states: IDLE, CMD, WAIT, EMIT.
- IDLE: when cfg_enable && (cfg_start || cfg_continuous), go to CMD with slot=0, sample=0, acc=0.
- CMD: command_valid=1 and command_channel=cfg_slot_ch[slot].
  - sop=1 iff slot==0 && sample==0.
  - eop=1 iff slot==NUM_SLOTS-1 && sample==2^AVG_LOG2-1.
  - On command_ready, go to WAIT.
  - Only one command is ever outstanding.
- WAIT: on response_valid, acc += response_data.
  - If response_channel != expected channel, set err_channel; the sample is still accumulated.
  - If sample is the last one, go to EMIT; otherwise increment sample and go to CMD.
- EMIT: result_valid=1 and result_data=acc[AVG_LOG2 +: DATA_W] (truncating divide). Clear acc and sample.
  - Not the last slot: increment slot, go to CMD.
  - Last slot: assert result_frame_end. Go to CMD at slot 0 if cfg_enable && cfg_continuous, otherwise go to IDLE.
- Accumulator width is DATA_W+AVG_LOG2 and cannot overflow.
- cfg_start while busy is ignored.
- Deasserting cfg_enable mid-frame does not abort; the frame completes.
- Responses outside WAIT are dropped silently.
- cfg_slot_ch is sampled at each CMD entry; software changes it only while idle.
- cfg_err_clr clears both error flags. A set event in the same cycle wins.

## Timing
- Reset values: every output is 0, the FSM is IDLE, and all counters are 0.
- command_valid rises on the cycle after the start condition.
- The command fields are registered and held stable until command_ready.
- result_valid is asserted the cycle after the final response of a slot and lasts exactly 1 cycle.
- Minimum cost per sample is 2 cycles (CMD with ready high, then WAIT with response). Each slot adds 1 cycle for EMIT.
- Asserting reset mid-frame returns the block immediately to IDLE. Any response still in flight afterwards is dropped.

## Configuration
- ADC_SCAN_TIMEOUT_EN defined:
  - A counter runs in WAIT.
  - After TIMEOUT_CYC cycles with no response, set err_timeout and return to CMD to reissue the same sample; acc is unchanged.
  - The counter clears on every WAIT entry.
- Not defined: WAIT holds indefinitely, err_timeout is tied 0, and no counter logic is generated.

## Structure
- Package adc_scan_pkg: FSM state enum, slot/sample width localparams, and a helper to extract the channel of a given slot.
- Sub-module adc_scan_acc: accumulator, sample counter, and shift-down averaging (clear, add, last, avg_out).

## Test plan
- NUM_SLOTS=4, AVG_LOG2=2, slots {3,5,7,1}, ADC model returns 100,101,102,103 per slot -> four results with data=101 and slots 0..3; result_frame_end only on slot 3.
- command_ready held low for 10 cycles -> command_valid/channel/sop stay stable; no second command is issued; the result is unchanged.
- cfg_continuous=1 -> frames run back to back. Clearing cfg_enable mid-frame -> the frame finishes, then busy=0.
- Model returns channel 2 when channel 3 was commanded -> err_channel=1 and the result is still emitted. cfg_err_clr -> 0.
- With ADC_SCAN_TIMEOUT_EN and TIMEOUT_CYC=16, drop one response -> err_timeout=1 at cycle 16 of WAIT, the same channel is reissued, and the averaged result is correct.
- Reset asserted during WAIT, then a stale response arrives -> outputs are 0, the response is ignored, and the next cfg_start begins at slot 0.

Source files
------------

// File: rtl/adc_scan_pkg.sv
// adc_scan_pkg: shared types and helpers for the ADC scan sequencer.
//   scan_state_t : sequencer FSM states (IDLE, CMD, WAIT, EMIT)
//   idx_w()      : index width for a count of n items (minimum 1 bit);
//                  gives the slot-index and sample-counter widths
//   slot_ch_lsb(): bit offset of a slot's channel field in the flat slot list
package adc_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WAIT = 2'd2,
    EMIT = 2'd3
  } scan_state_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned slot_ch_lsb(input int unsigned slot,
                                              input int unsigned ch_w);
    return slot * ch_w;
  endfunction

endpackage

// File: rtl/adc_scan_acc.sv
// adc_scan_acc: per-slot sample accumulator and averaging.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero the accumulator and the sample counter
//   add        : accumulate add_data; advance the sample counter unless last
//   add_data   : incoming ADC sample
//   sample     : index of the sample currently being collected
//   last       : sample is the final one of the averaging window
//   avg_out    : running sum (including a sample being added this cycle)
//                shifted down by AVG_LOG2 (truncating divide)
module adc_scan_acc
  import adc_scan_pkg::*;
#(
  parameter  int unsigned DATA_W   = 12,
  parameter  int unsigned AVG_LOG2 = 2,
  localparam int unsigned SMP_W    = idx_w(1 << AVG_LOG2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              add,
  input  logic [DATA_W-1:0] add_data,
  output logic [SMP_W-1:0]  sample,
  output logic              last,
  output logic [DATA_W-1:0] avg_out
);

  localparam int unsigned ACC_W = DATA_W + AVG_LOG2;
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;

  // The sum includes the sample being added so the final average is ready
  // on the same edge that captures the last response.
  always_comb begin
    acc_sum = acc + (add ? ACC_W'(add_data) : '0);
  end

  assign last    = (sample == SMP_LAST);
  assign avg_out = DATA_W'(acc_sum >> AVG_LOG2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      sample <= '0;
    end else if (clear) begin
      acc    <= '0;
      sample <= '0;
    end else if (add) begin
      acc <= acc_sum;
      if (!last) begin
        sample <= sample + 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: scan sequencer for the modular ADC command/response pair.
// Walks NUM_SLOTS programmed channels, averages 2^AVG_LOG2 conversions per
// slot and emits one result per slot.
//   clock_clk, reset_sink_reset_n : clock, asynchronous active-low reset
//   cfg_*        : enable, continuous mode, start pulse, error clear, slot list
//   command_*    : Avalon-ST command out (one command outstanding at a time)
//   response_*   : Avalon-ST response in (sop/eop ignored)
//   result_*     : one-cycle averaged result strobe with slot index/frame end
//   busy         : sequencer not idle
//   err_channel  : sticky, response channel differed from the command
//   err_timeout  : sticky, response watchdog fired
// Build option: define ADC_SCAN_TIMEOUT_EN to enable the response watchdog
// (TIMEOUT_CYC cycles); otherwise WAIT holds forever and err_timeout is 0.
module adc_scan_ctrl
  import adc_scan_pkg::*;
#(
  parameter  int unsigned NUM_SLOTS   = 4,
  parameter  int unsigned CH_W        = 5,
  parameter  int unsigned DATA_W      = 12,
  parameter  int unsigned AVG_LOG2    = 2,
  parameter  int unsigned TIMEOUT_CYC = 1024,
  localparam int unsigned SW          = idx_w(NUM_SLOTS)
) (
  input  logic                      clock_clk,
  input  logic                      reset_sink_reset_n,
  input  logic                      cfg_enable,
  input  logic                      cfg_continuous,
  input  logic                      cfg_start,
  input  logic                      cfg_err_clr,
  input  logic [NUM_SLOTS*CH_W-1:0] cfg_slot_ch,
  output logic                      command_valid,
  output logic [CH_W-1:0]           command_channel,
  output logic                      command_startofpacket,
  output logic                      command_endofpacket,
  input  logic                      command_ready,
  input  logic                      response_valid,
  input  logic [CH_W-1:0]           response_channel,
  input  logic [DATA_W-1:0]         response_data,
  input  logic                      response_startofpacket,
  input  logic                      response_endofpacket,
  output logic                      result_valid,
  output logic [SW-1:0]             result_slot,
  output logic [DATA_W-1:0]         result_data,
  output logic                      result_frame_end,
  output logic                      busy,
  output logic                      err_channel,
  output logic                      err_timeout
);

  localparam int unsigned SMP_W = idx_w(1 << AVG_LOG2);
  localparam logic [SW-1:0]    LAST_SLOT = SW'(NUM_SLOTS - 1);
  localparam logic [SMP_W-1:0] LAST_SMP  = SMP_W'((1 << AVG_LOG2) - 1);

  scan_state_t      state;
  logic [SW-1:0]    slot;
  logic [SMP_W-1:0] sample;
  logic             acc_clear;
  logic             acc_add;
  logic             acc_last;
  logic [DATA_W-1:0] acc_avg;

  logic             load_cmd;
  logic [SW-1:0]    ld_slot;
  logic [SMP_W-1:0] ld_sample;
  logic             wd_fire;

  logic unused_ok;
  assign unused_ok = &{1'b0, response_startofpacket, response_endofpacket,
                       (TIMEOUT_CYC == 0)};

  function automatic logic [CH_W-1:0] slot_channel(input logic [SW-1:0] s);
    return cfg_slot_ch[slot_ch_lsb(32'(s), CH_W) +: CH_W];
  endfunction

  adc_scan_acc #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_acc (
    .clk      (clock_clk),
    .rst_n    (reset_sink_reset_n),
    .clear    (acc_clear),
    .add      (acc_add),
    .add_data (response_data),
    .sample   (sample),
    .last     (acc_last),
    .avg_out  (acc_avg)
  );

  assign acc_clear = (state == IDLE) || (state == EMIT);
  assign acc_add   = (state == WAIT) && response_valid;
  assign busy      = (state != IDLE);

`ifdef ADC_SCAN_TIMEOUT_EN
  localparam int unsigned WD_W = idx_w(TIMEOUT_CYC);
  logic [WD_W-1:0] wdog;
  // A response arriving on the expiry cycle takes priority over the timeout.
  assign wd_fire = (state == WAIT) && !response_valid &&
                   (wdog == WD_W'(TIMEOUT_CYC - 1));
`else
  assign wd_fire     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Every transition into CMD is decoded here so the registered command
  // fields are loaded from one place, with sop/eop derived from the target
  // slot/sample rather than the current ones.
  always_comb begin
    load_cmd  = 1'b0;
    ld_slot   = slot;
    ld_sample = sample;
    case (state)
      IDLE: begin
        if (cfg_enable && (cfg_start || cfg_continuous)) begin
          load_cmd  = 1'b1;
          ld_slot   = '0;
          ld_sample = '0;
        end
      end
      WAIT: begin
        if (response_valid && !acc_last) begin
          load_cmd  = 1'b1;
          ld_sample = sample + 1'b1;
        end else if (wd_fire) begin
          load_cmd = 1'b1;
        end
      end
      EMIT: begin
        if (slot != LAST_SLOT) begin
          load_cmd  = 1'b1;
          ld_slot   = slot + 1'b1;
          ld_sample = '0;
        end else if (cfg_enable && cfg_continuous) begin
          load_cmd  = 1'b1;
          ld_slot   = '0;
          ld_sample = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
    if (!reset_sink_reset_n) begin
      state                 <= IDLE;
      slot                  <= '0;
      command_valid         <= 1'b0;
      command_channel       <= '0;
      command_startofpacket <= 1'b0;
      command_endofpacket   <= 1'b0;
      result_valid          <= 1'b0;
      result_slot           <= '0;
      result_data           <= '0;
      result_frame_end      <= 1'b0;
      err_channel           <= 1'b0;
`ifdef ADC_SCAN_TIMEOUT_EN
      err_timeout           <= 1'b0;
      wdog                  <= '0;
`endif
    end else begin
      result_valid     <= 1'b0;
      result_frame_end <= 1'b0;

      // Clear first so a same-cycle error event below overrides it.
      if (cfg_err_clr) begin
        err_channel <= 1'b0;
`ifdef ADC_SCAN_TIMEOUT_EN
        err_timeout <= 1'b0;
`endif
      end

      if (load_cmd) begin
        state                 <= CMD;
        slot                  <= ld_slot;
        command_valid         <= 1'b1;
        command_channel       <= slot_channel(ld_slot);
        command_startofpacket <= (ld_slot == '0) && (ld_sample == '0);
        command_endofpacket   <= (ld_slot == LAST_SLOT) && (ld_sample == LAST_SMP);
      end

      case (state)
        IDLE: ;
        CMD: begin
          if (command_ready) begin
            command_valid <= 1'b0;
            state         <= WAIT;
`ifdef ADC_SCAN_TIMEOUT_EN
            wdog          <= '0;
`endif
          end
        end
        WAIT: begin
          if (response_valid) begin
            if (response_channel != command_channel) begin
              err_channel <= 1'b1;
            end
            if (acc_last) begin
              state            <= EMIT;
              result_valid     <= 1'b1;
              result_slot      <= slot;
              result_data      <= acc_avg;
              result_frame_end <= (slot == LAST_SLOT);
            end
          end
`ifdef ADC_SCAN_TIMEOUT_EN
          else if (wd_fire) begin
            err_timeout <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
`endif
        end
        EMIT: begin
          if (!load_cmd) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
